// File: rtl/mem_pkg.sv
// Shared types for the SRAM-like memory path.
// Source IDs and access-size encodings.
package mem_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } mem_src_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic mem_src_e other_src(
    input mem_src_e s
  );
    return (s == SRC_INST) ? SRC_DATA : SRC_INST;
  endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// In-order FIFO of source IDs for accepted requests.
// Depth must be a power of two, at least 2.
module sram_id_fifo
  import mem_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = mem_src_e
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rptr];

  // A pop in the same cycle frees the slot for a push.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges inst and data SRAM-like masters onto one slave.
// Round-robin grant, lock on stall, in-order response routing.
module sram_like_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  output logic              err
);

  logic     r_lock;
  mem_src_e r_lock_src;
  mem_src_e r_last;
  logic     r_err;

  mem_src_e w_src;
  mem_src_e w_head;
  logic     w_gnt_req;
  logic     w_full;
  logic     w_empty;
  logic     w_pop;
  logic     w_push;
  logic     w_drop;

  always_comb begin
    w_src     = SRC_INST;
    w_gnt_req = 1'b0;
    if (r_lock) begin
      w_src     = r_lock_src;
      w_gnt_req = (r_lock_src == SRC_INST) ?
                  inst_req : data_req;
    end else if (inst_req && data_req) begin
      w_src     = other_src(r_last);
      w_gnt_req = 1'b1;
    end else if (data_req) begin
      w_src     = SRC_DATA;
      w_gnt_req = 1'b1;
    end else begin
      w_src     = SRC_INST;
      w_gnt_req = inst_req;
    end
  end

  assign w_drop = r_lock & ~w_gnt_req;
  assign w_pop  = ~rst & m_data_ok & ~w_empty;
  assign m_req  = ~rst & w_gnt_req
                & (~w_full | w_pop);
  assign w_push = m_req & m_addr_ok;

  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'b00;
    m_addr  = '0;
    m_wdata = '0;
    if (m_req) begin
      if (w_src == SRC_DATA) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_size  = SIZE_WORD;
        m_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = w_push
                      & (w_src == SRC_INST);
  assign data_addr_ok = w_push
                      & (w_src == SRC_DATA);

  assign inst_data_ok = w_pop
                      & (w_head == SRC_INST);
  assign data_data_ok = w_pop
                      & (w_head == SRC_DATA);
  assign inst_rdata   = inst_data_ok ?
                        m_rdata : '0;
  assign data_rdata   = data_data_ok ?
                        m_rdata : '0;

  assign err = r_err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lock_src <= SRC_INST;
      r_last     <= SRC_DATA;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_last <= w_src;
        r_lock <= 1'b0;
      end else if (w_drop) begin
        r_lock <= 1'b0;
      end else if (m_req) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_src;
      end
      // Protocol faults: dropped locked req, response with nothing pending.
      if (w_drop || (m_data_ok && w_empty))
        r_err <= 1'b1;
    end
  end

  sram_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (mem_src_e)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_src),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with a small in-order slave model.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic        err;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .MAX_OUTSTANDING (4),
    .ADDR_W          (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .err          (err)
  );

  // Slave: manual (table) or automatic in-order with latency.
  typedef struct {
    int          due;
    logic [31:0] rdata;
  } slv_t;

  slv_t        sq[$];
  logic [31:0] mem [256];
  logic        slv_auto;
  logic        slv_accept;
  logic        slv_force;
  logic [31:0] slv_frdata;
  int          slv_lat;
  logic        auto_dok;
  logic [31:0] auto_rdata;
  logic        man_aok;
  logic        man_dok;
  logic [31:0] man_rdata;
  int          cyc;

  always_comb begin
    m_addr_ok = man_aok;
    m_data_ok = man_dok;
    m_rdata   = man_rdata;
    if (slv_auto) begin
      m_addr_ok = slv_accept;
      m_data_ok = auto_dok | slv_force;
      m_rdata   = slv_force ? slv_frdata : auto_rdata;
    end
  end

  logic        s_mreq;
  logic [31:0] s_maddr;
  logic        s_iaok;
  logic        s_daok;
  logic        s_idok;
  logic        s_ddok;
  logic [31:0] s_irdata;
  logic [31:0] s_drdata;
  logic        s_err;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic        eq[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    slv_t        e;
    logic [7:0]  idx;
    logic [1:0]  ln;
    @(negedge clk);
    s_mreq   = m_req;
    s_maddr  = m_addr;
    s_iaok   = inst_addr_ok;
    s_daok   = data_addr_ok;
    s_idok   = inst_data_ok;
    s_ddok   = data_data_ok;
    s_irdata = inst_rdata;
    s_drdata = data_rdata;
    s_err    = err;
    if (s_idok) iq.push_back(s_irdata);
    if (s_ddok) dq.push_back(s_drdata);
    if (slv_auto) begin
      if (rst) sq.delete();
      else begin
        if (auto_dok && sq.size() > 0) void'(sq.pop_front());
        if (m_req && m_addr_ok) begin
          idx = m_addr[9:2];
          ln  = m_addr[1:0];
          e.rdata = 32'h0;
          if (m_wr) begin
            if (m_size == 2'b00)
              mem[idx][ln*8 +: 8] = m_wdata[7:0];
            else if (m_size == 2'b01)
              mem[idx][ln[1]*16 +: 16] = m_wdata[15:0];
            else
              mem[idx] = m_wdata;
          end else begin
            e.rdata = mem[idx];
          end
          e.due = cyc + slv_lat;
          sq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    auto_dok   = 1'b0;
    auto_rdata = 32'h0;
    if (slv_auto && sq.size() > 0) begin
      if (sq[0].due <= cyc) begin
        auto_dok   = 1'b1;
        auto_rdata = sq[0].rdata;
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    inst_req  = 1'b0;
    data_req  = 1'b0;
    data_wr   = 1'b0;
    data_size = 2'b10;
    data_addr = 32'h204;
    slv_force = 1'b0;
    tick();
    rst = 1'b0;
    iq.delete();
    dq.delete();
    eq.delete();
  endtask

  task automatic chk_resp();
    logic        s;
    logic [31:0] ex;
    if (s_idok || s_ddok) begin
      chk("B resp pending", 32'(eq.size() > 0), 1);
      if (eq.size() > 0) begin
        s  = eq.pop_front();
        ex = s ? 32'h22220000 : 32'hDEADBEEF;
        chk("B resp src", {s_idok, s_ddok},
            s ? 2'b01 : 2'b10);
        chk("B resp data",
            s ? s_drdata : s_irdata, ex);
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        mreq;
    logic [31:0] maddr;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic        ddok;
    logic [31:0] irdata;
    logic [31:0] drdata;
    logic        err;
  } vec_t;

  vec_t tv [17];

  initial begin
    int          k;
    int          n;
    int          n_acc;
    int          ncyc;
    logic        nxt;
    logic        exp_a;
    logic        exp_d;

    tv[0]  = '{1,1,1,1,1,32'h55,      0,32'h0,  0,0,0,0,32'h0,32'h0,0};
    tv[1]  = '{0,1,0,1,0,32'h0,       1,32'h100,1,0,0,0,32'h0,32'h0,0};
    tv[2]  = '{0,0,0,1,1,32'hDEADBEEF,0,32'h0,  0,0,1,0,32'hDEADBEEF,32'h0,0};
    tv[3]  = '{0,1,1,1,0,32'h0,       1,32'h204,0,1,0,0,32'h0,32'h0,0};
    tv[4]  = '{0,1,1,1,0,32'h0,       1,32'h100,1,0,0,0,32'h0,32'h0,0};
    tv[5]  = '{0,1,0,0,0,32'h0,       1,32'h100,0,0,0,0,32'h0,32'h0,0};
    tv[6]  = '{0,1,1,0,1,32'hA1,      1,32'h100,0,0,0,1,32'h0,32'hA1,0};
    tv[7]  = '{0,1,1,1,0,32'h0,       1,32'h100,1,0,0,0,32'h0,32'h0,0};
    tv[8]  = '{0,0,1,1,1,32'hB2,      1,32'h204,0,1,1,0,32'hB2,32'h0,0};
    tv[9]  = '{0,0,0,1,1,32'hC3,      0,32'h0,  0,0,1,0,32'hC3,32'h0,0};
    tv[10] = '{0,0,0,1,1,32'hD4,      0,32'h0,  0,0,0,1,32'h0,32'hD4,0};
    tv[11] = '{0,0,0,1,1,32'hE5,      0,32'h0,  0,0,0,0,32'h0,32'h0,0};
    tv[12] = '{0,0,0,1,0,32'h0,       0,32'h0,  0,0,0,0,32'h0,32'h0,1};
    tv[13] = '{1,0,0,1,0,32'h0,       0,32'h0,  0,0,0,0,32'h0,32'h0,0};
    tv[14] = '{0,0,1,0,0,32'h0,       1,32'h204,0,0,0,0,32'h0,32'h0,0};
    tv[15] = '{0,0,0,0,0,32'h0,       0,32'h0,  0,0,0,0,32'h0,32'h0,0};
    tv[16] = '{0,0,0,0,0,32'h0,       0,32'h0,  0,0,0,0,32'h0,32'h0,1};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h80] = 32'h11223344;
    mem[8'h81] = 32'h22220000;

    cyc        = 0;
    slv_auto   = 1'b0;
    slv_accept = 1'b1;
    slv_force  = 1'b0;
    slv_frdata = 32'h0;
    slv_lat    = 1;
    auto_dok   = 1'b0;
    auto_rdata = 32'h0;
    inst_addr  = 32'h100;
    data_addr  = 32'h204;
    data_wr    = 1'b0;
    data_size  = 2'b10;
    data_wdata = 32'h0;

    for (int i = 0; i < 17; i++) begin
      rst       = tv[i].rst;
      inst_req  = tv[i].ireq;
      data_req  = tv[i].dreq;
      man_aok   = tv[i].aok;
      man_dok   = tv[i].dok;
      man_rdata = tv[i].rdata;
      tick();
      chk($sformatf("T%0d m_req", i), s_mreq, tv[i].mreq);
      chk($sformatf("T%0d m_addr", i), s_maddr, tv[i].maddr);
      chk($sformatf("T%0d i_aok", i), s_iaok, tv[i].iaok);
      chk($sformatf("T%0d d_aok", i), s_daok, tv[i].daok);
      chk($sformatf("T%0d i_dok", i), s_idok, tv[i].idok);
      chk($sformatf("T%0d d_dok", i), s_ddok, tv[i].ddok);
      chk($sformatf("T%0d i_rd", i), s_irdata, tv[i].irdata);
      chk($sformatf("T%0d d_rd", i), s_drdata, tv[i].drdata);
      chk($sformatf("T%0d err", i), s_err, tv[i].err);
    end

    // A: single fetch, latency 3
    slv_auto   = 1'b1;
    slv_accept = 1'b1;
    slv_lat    = 3;
    do_reset();
    inst_req = 1'b1;
    tick();
    chk("A iaok c0", s_iaok, 1);
    inst_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("A idok c%0d", c), s_idok, 32'(c == 3));
      chk($sformatf("A ddok c%0d", c), s_ddok, 0);
    end
    chk("A rdata", s_irdata, 32'hDEADBEEF);
    repeat (3) tick();
    chk("A no data resp", dq.size(), 0);

    // B: contention, zero-wait slave
    slv_lat = 1;
    do_reset();
    inst_req = 1'b1;
    data_req = 1'b1;
    nxt   = 1'b0;
    n_acc = 0;
    ncyc  = 0;
    while (n_acc < 16 && ncyc < 64) begin
      tick();
      ncyc++;
      if (s_iaok || s_daok) begin
        chk("B grant", {s_iaok, s_daok},
            nxt ? 2'b01 : 2'b10);
        eq.push_back(nxt);
        nxt = ~nxt;
        n_acc++;
      end
      chk_resp();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk_resp();
    end
    chk("B accepts", n_acc, 16);
    chk("B cycles", ncyc, 16);
    chk("B drained", eq.size(), 0);

    // C: byte write then word read
    do_reset();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'b00;
    data_addr  = 32'h203;
    data_wdata = 32'h000000AA;
    k = 0;
    do begin tick(); k++; end
    while (!s_daok && k < 8);
    chk("C write accepted", s_daok, 1);
    data_wr   = 1'b0;
    data_size = 2'b10;
    data_addr = 32'h200;
    k = 0;
    do begin tick(); k++; end
    while (!s_daok && k < 8);
    chk("C read accepted", s_daok, 1);
    data_req = 1'b0;
    repeat (4) tick();
    chk("C resp count", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("C write resp", dq[0], 32'h0);
      chk("C read data", dq[1], 32'hAA223344);
    end
    chk("C no inst resp", iq.size(), 0);

    // D: backpressure holds the data grant
    do_reset();
    slv_accept = 1'b0;
    data_req   = 1'b1;
    tick();
    chk("D c0 m_req", s_mreq, 1);
    chk("D c0 m_addr", s_maddr, 32'h204);
    chk("D c0 daok", s_daok, 0);
    inst_req = 1'b1;
    tick();
    chk("D c1 m_addr", s_maddr, 32'h204);
    chk("D c1 iaok", s_iaok, 0);
    chk("D c1 daok", s_daok, 0);
    slv_accept = 1'b1;
    tick();
    chk("D c2 daok", s_daok, 1);
    chk("D c2 iaok", s_iaok, 0);
    chk("D c2 m_addr", s_maddr, 32'h204);
    tick();
    chk("D c3 iaok", s_iaok, 1);
    chk("D c3 m_addr", s_maddr, 32'h100);
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (4) tick();

    // E: FIFO fills with latency 6
    slv_lat = 6;
    do_reset();
    inst_req = 1'b1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      exp_d = (c >= 6 && c <= 9) || c >= 12;
      exp_a = c < 4 || exp_d;
      chk($sformatf("E accept c%0d", c), s_iaok, exp_a);
      chk($sformatf("E m_req c%0d", c), s_mreq, exp_a);
      chk($sformatf("E idok c%0d", c), s_idok, exp_d);
      n += int'(s_iaok);
      if (c == 5) chk("E accepts before pop", n, 4);
    end
    inst_req = 1'b0;

    // F: stray response, then reset with traffic in flight
    do_reset();
    slv_force  = 1'b1;
    slv_frdata = 32'h99;
    tick();
    chk("F stray idok", s_idok, 0);
    chk("F stray ddok", s_ddok, 0);
    chk("F err same cycle", s_err, 0);
    slv_force = 1'b0;
    tick();
    chk("F err set", s_err, 1);
    inst_req = 1'b1;
    n = 0;
    repeat (3) begin tick(); n += int'(s_iaok); end
    chk("F accepts", n, 3);
    chk("F err sticky", s_err, 1);
    rst      = 1'b1;
    data_req = 1'b1;
    tick();
    chk("F rst m_req", s_mreq, 0);
    chk("F rst iaok", s_iaok, 0);
    chk("F rst daok", s_daok, 0);
    chk("F rst idok", s_idok, 0);
    chk("F rst ddok", s_ddok, 0);
    chk("F rst err", s_err, 0);
    rst      = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    iq.delete();
    tick();
    chk("F err cleared", s_err, 0);
    repeat (8) tick();
    chk("F flushed", iq.size(), 0);
    slv_force = 1'b1;
    tick();
    chk("F post idok", s_idok, 0);
    slv_force = 1'b0;
    tick();
    chk("F post err", s_err, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Merges the CPU instruction-fetch and data-access SRAM-like master ports onto a single SRAM-like slave port (the unified test/backing RAM).
- Arbitrates requests round-robin and tracks accepted requests in an in-order source-ID FIFO, so each slave data_ok/rdata is routed back to the master that issued it.
- Sits between the pipeline's IF/MEM stages and the memory slave; the slave responds in order with fixed or variable latency.

Parameters:
- MAX_OUTSTANDING, 4, depth of the source-ID FIFO (≥ slave latency + 1 for full throughput); power of two.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- inst_req  input  1  fetch request
- inst_addr  input  32  fetch address (always a word read, size 2'b10)
- inst_rdata  output  32  fetch read data
- inst_addr_ok  output  1  fetch request accepted
- inst_data_ok  output  1  fetch data valid
- data_req  input  1  data request
- data_wr  input  1  1 = write
- data_size  input  2  00 byte, 01 half, 10 word
- data_addr  input  32  data address
- data_wdata  input  32  write data
- data_rdata  output  32  read data
- data_addr_ok  output  1  data request accepted
- data_data_ok  output  1  data response (reads and writes)
- m_req  output  1  slave request
- m_wr  output  1  slave write
- m_size  output  2  slave size
- m_addr  output  32  slave address
- m_wdata  output  32  slave write data
- m_rdata  input  32  slave read data
- m_addr_ok  input  1  slave accepted request
- m_data_ok  input  1  slave response valid
- err  output  1  sticky protocol error

Behaviour:
- Reset: FIFO empty, lock clear, last_grant = DATA (inst wins the first conflict), err = 0. While rst = 1: m_req = 0, all *_addr_ok = 0, all *_data_ok = 0, all rdata = 0.
- Grant selection (combinational, while unlocked):
  - only one master requesting → grant it;
  - both requesting → grant the master that is not last_grant.
- Lock register:
  - Set when m_req = 1 and m_addr_ok = 0; holds the granted source until a handshake occurs.
  - Grant must not change while locked, even if the other master raises req.
  - A locked master that drops req violates protocol: set err, clear lock.
- Request issue:
  - m_req = granted_req & !fifo_full.
  - m_wr/m_size/m_addr/m_wdata come from the granted master; for inst: wr = 0, size = 2'b10, wdata = 0.
  - The non-granted master sees addr_ok = 0.
- Handshake (m_req & m_addr_ok):
  - Granted master's addr_ok = 1 in the same cycle (combinational passthrough, zero added latency).
  - Push source ID; last_grant <= source; lock clears.
- Response (m_data_ok):
  - Pop the FIFO head. Drive that source's data_ok = 1 and rdata = m_rdata in the same cycle (combinational).
  - The other master's data_ok = 0 and rdata = 0.
- Simultaneous push and pop in one cycle: allowed; occupancy unchanged; works when full (the pop frees the slot this cycle, so m_req may assert when full & m_data_ok).
- m_data_ok with FIFO empty: response dropped, err <= 1 (sticky until rst).
- FIFO full without a pop: m_req = 0 and no addr_ok; pending requests wait and are not lost.
- Ordering: responses are strictly in acceptance order; the FIFO is in order only, with no reordering.
- Reset mid-operation: FIFO flushed. The slave is reset on the same rst, so in-flight responses are discarded. Any stray data_ok after release sets err.
- Throughput: with a zero-wait slave and depth ≥ latency + 1, one request is accepted per cycle; both masters alternate under contention.

Decomposition:
- Shared package mem_pkg:
  - typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} mem_src_e;
  - size constants SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
- One sub-module, sram_id_fifo: parameterised depth and width (mem_src_e).
  - Ports: push, push_data, pop, head, full, empty.
  - Pointer wrap on power-of-two depth; count register allows simultaneous push/pop.

Test Plan:
- Single inst read: inst_req with addr 0x100, slave latency 3 with mem[0x40] = 0xDEADBEEF → inst_addr_ok in cycle 0, inst_data_ok = 1 with inst_rdata = 0xDEADBEEF in cycle 3; data_data_ok never asserts.
- Contention: inst_req and data_req held every cycle after reset → grants alternate I,D,I,D…; responses routed in the same order; no starvation across 16 requests.
- Write then read: data_wr size 00 at addr 0x203 with wdata 0x000000AA, then data read of 0x200 → data_data_ok for the write, then rdata[31:24] = 0xAA with the other bytes unchanged.
- Backpressure/lock: slave holds m_addr_ok = 0 for 2 cycles while data is granted, and inst_req rises mid-wait → m_addr stays the data address, inst_addr_ok = 0 until data handshakes, then inst is granted next.
- FIFO full: MAX_OUTSTANDING = 4, slave latency 6, requests every cycle → exactly 4 accepted, m_req = 0 until the first data_ok, then one accept per pop.
- Error/reset: inject m_data_ok with an empty FIFO → err = 1 next cycle and no master data_ok; assert rst with 3 outstanding → err = 0, FIFO empty, all outputs 0 for the rst cycle.
